burst_sequencer: RTL and testbench
==================================

// Module: burst_sequencer
// PURPOSE
//  Measurement scheduler for one ultrasonic channel. Drives pulse_generation (burst_en,
//  burst_rstn), waits for burst_finish, blanks transducer ring-down, then times the echo.
//  Reports time-of-flight in gclk cycles; single-shot or free-running repetition.
//  Sits between main control logic and pulse_generation / the echo comparator input.
// PARAMETERS
//  CNT_W        20      width of TOF counter and all cycle counts
//  BLANK_CYC    27000   cycles after FIRE entry before echo accepted (1 ms @ 27 MHz)
//  TIMEOUT_CYC  810000  TOF count at which listening gives up (30 ms); < 2**CNT_W-1
//  HOLDOFF_CYC  270000  idle gap between measurements in auto mode (10 ms)
//  FIRE_MAX_CYC 4096    watchdog: max cycles in FIRE waiting for burst_finish
// PORTS
//  gclk         in   1      clock, 27 MHz
//  rstn         in   1      reset, asynchronous, active-low
//  start        in   1      single-shot request, sampled in IDLE only
//  auto_en      in   1      level: repeat measurements every HOLDOFF_CYC
//  abort        in   1      synchronous abort, any state -> IDLE
//  burst_finish in   1      from pulse_generation, high once burst is complete
//  echo_det     in   1      asynchronous comparator output, high = echo present
//  burst_en     out  1      to pulse_generation, enables burst
//  burst_rstn   out  1      to pulse_generation, low parks the generator
//  busy         out  1      high in any state other than IDLE
//  tof_valid    out  1      one-cycle pulse: tof_cycles/timeout updated
//  tof_cycles   out  CNT_W  captured TOF; all-ones on timeout
//  timeout      out  1      sticky until next tof_valid: last result was a timeout
//  fire_err     out  1      one-cycle pulse: FIRE watchdog expired
// BEHAVIOUR
//  Reset: state=IDLE; burst_en=0, burst_rstn=0, busy=0, tof_valid=0, tof_cycles=0,
//   timeout=0, fire_err=0, cnt=0. All outputs are registered.
//  States: IDLE, FIRE, BLANK, LISTEN, DONE, HOLDOFF.
//  IDLE: (start|auto_en) -> FIRE. cnt cleared to 0 on FIRE entry and incremented
//   every cycle in FIRE/BLANK/LISTEN, saturating at all-ones.
//  FIRE: burst_en=1, burst_rstn=1 for every FIRE cycle. burst_finish=1 -> BLANK.
//   cnt==FIRE_MAX_CYC-1 without burst_finish -> fire_err pulse, -> IDLE, no tof_valid.
//  BLANK: burst_en=0, burst_rstn=0. Echo edges ignored. cnt>=BLANK_CYC-1 -> LISTEN.
//   If burst_finish comes after BLANK_CYC cycles, go directly FIRE -> LISTEN.
//  LISTEN: rising edge of synchronized echo -> tof_cycles=cnt, timeout=0, -> DONE.
//   cnt==TIMEOUT_CYC-1 with no edge -> tof_cycles='1, timeout=1, -> DONE.
//   Edge and timeout in the same cycle: the echo wins.
//  echo_det passes a 2-FF synchronizer plus an edge detector. If echo_det is high at
//   the edge where cnt=N, tof_cycles=N+2. No compensation for the 2-cycle delay.
//   An echo still high when LISTEN starts is not an edge and is ignored.
//  DONE (1 cycle): tof_valid=1. -> HOLDOFF if auto_en, else IDLE.
//  HOLDOFF: counts HOLDOFF_CYC cycles, then -> FIRE if auto_en, else IDLE.
//   Dropping auto_en ends the run after the measurement in progress.
//  start outside IDLE is ignored (not queued). burst_rstn=0 in every non-FIRE state.
//  abort: highest priority. Next cycle: IDLE, burst_en=0, burst_rstn=0.
//   No tof_valid; tof_cycles and timeout hold their previous values.
//  rstn low mid-operation: immediate asynchronous return to reset values.
// STRUCTURE
//  ultra_pkg: state encoding (localparam enum), default cycle constants at 27 MHz.
//  Sub-module sync_edge: 2-FF synchronizer + rising-edge pulse (gclk, rstn, d -> rise).
//  Sequencer FSM, TOF counter and holdoff counter live in this module.
// TESTING (bench parameters: BLANK=10, TIMEOUT=100, HOLDOFF=20, FIRE_MAX=50, CNT_W=8)
//  1 Reset held, all inputs toggled -> burst_en=0, burst_rstn=0, busy=0,
//    tof_valid=0, tof_cycles=0.
//  2 start pulse; burst_finish at cnt=30; echo_det high at cnt=60 -> one tof_valid,
//    tof_cycles=62, timeout=0; burst_en high exactly cnt 0..30.
//  3 echo_det high from cnt=5 onward, never falls -> no capture; at cnt=99
//    tof_cycles=8'hFF, timeout=1.
//  4 burst_finish never asserted -> fire_err pulse at cnt=49, burst_rstn=0,
//    IDLE, no tof_valid.
//  5 auto_en=1, echo each cycle at cnt=40 -> FIRE entries spaced by DONE+20 holdoff
//    cycles; drop auto_en mid-LISTEN -> one more tof_valid, then IDLE.
//  6 abort at cnt=70 in LISTEN -> IDLE next cycle, no tof_valid. Echo edge seen at
//    cnt=99 -> tof_cycles=99, timeout=0.

Source files
------------

// File: rtl/ultra_pkg.sv
// Shared types and default timing constants for the ultrasonic channel.
// Defaults assume a 27 MHz gclk.
package ultra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRE    = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LISTEN  = 3'd3,
    ST_DONE    = 3'd4,
    ST_HOLDOFF = 3'd5
  } seq_state_t;

  localparam int unsigned CNT_W_DEF        = 20;
  localparam int unsigned BLANK_CYC_DEF    = 27000;
  localparam int unsigned TIMEOUT_CYC_DEF  = 810000;
  localparam int unsigned HOLDOFF_CYC_DEF  = 270000;
  localparam int unsigned FIRE_MAX_CYC_DEF = 4096;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector on the synchronized signal.
module sync_edge (
  input  logic gclk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      sh <= 3'b000;
    end else begin
      sh <= {sh[1:0], d};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/burst_sequencer.sv
// Measurement scheduler for one ultrasonic channel: fire, blank,
// listen for the echo, report time-of-flight in gclk cycles.
module burst_sequencer
  import ultra_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned BLANK_CYC    = BLANK_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
  parameter int unsigned FIRE_MAX_CYC = FIRE_MAX_CYC_DEF
) (
  input  logic             gclk,
  input  logic             rstn,
  input  logic             start,
  input  logic             auto_en,
  input  logic             abort,
  input  logic             burst_finish,
  input  logic             echo_det,
  output logic             burst_en,
  output logic             burst_rstn,
  output logic             busy,
  output logic             tof_valid,
  output logic [CNT_W-1:0] tof_cycles,
  output logic             timeout,
  output logic             fire_err
);

  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] FIRE_LAST =
    CNT_W'(FIRE_MAX_CYC - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hcnt;
  logic             echo_rise;

  sync_edge u_echo (
    .gclk (gclk),
    .rstn (rstn),
    .d    (echo_det),
    .rise (echo_rise)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      burst_en   <= 1'b0;
      burst_rstn <= 1'b0;
      busy       <= 1'b0;
      tof_valid  <= 1'b0;
      tof_cycles <= '0;
      timeout    <= 1'b0;
      fire_err   <= 1'b0;
    end else begin
      tof_valid <= 1'b0;
      fire_err  <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        burst_en   <= 1'b0;
        burst_rstn <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start | auto_en) begin
              state      <= ST_FIRE;
              cnt        <= '0;
              burst_en   <= 1'b1;
              burst_rstn <= 1'b1;
              busy       <= 1'b1;
            end
          end
          ST_FIRE: begin
            cnt <= cnt_inc;
            // a late finish skips blanking: it is already over
            if (burst_finish) begin
              state      <= (cnt >= BLANK_LAST) ?
                            ST_LISTEN : ST_BLANK;
              burst_en   <= 1'b0;
              burst_rstn <= 1'b0;
            end else if (cnt == FIRE_LAST) begin
              state      <= ST_IDLE;
              fire_err   <= 1'b1;
              burst_en   <= 1'b0;
              burst_rstn <= 1'b0;
              busy       <= 1'b0;
            end
          end
          ST_BLANK: begin
            cnt <= cnt_inc;
            if (cnt >= BLANK_LAST) begin
              state <= ST_LISTEN;
            end
          end
          ST_LISTEN: begin
            cnt <= cnt_inc;
            if (echo_rise) begin
              state      <= ST_DONE;
              tof_cycles <= cnt;
              timeout    <= 1'b0;
              tof_valid  <= 1'b1;
            end else if (cnt == TMO_LAST) begin
              state      <= ST_DONE;
              tof_cycles <= '1;
              timeout    <= 1'b1;
              tof_valid  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (auto_en) begin
              state <= ST_HOLDOFF;
              hcnt  <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          ST_HOLDOFF: begin
            if (hcnt == HOLD_LAST) begin
              if (auto_en) begin
                state      <= ST_FIRE;
                cnt        <= '0;
                burst_en   <= 1'b1;
                burst_rstn <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          default: begin
            state      <= ST_IDLE;
            burst_en   <= 1'b0;
            burst_rstn <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed checks for burst_sequencer with short timing parameters.
// Cycle index c counts cycles from FIRE entry, matching the DUT's cnt.
module tb_burst_sequencer;

  logic       gclk = 1'b0;
  logic       rstn;
  logic       start;
  logic       auto_en;
  logic       abort;
  logic       burst_finish;
  logic       echo_det;
  logic       burst_en;
  logic       burst_rstn;
  logic       busy;
  logic       tof_valid;
  logic [7:0] tof_cycles;
  logic       timeout;
  logic       fire_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 gclk = ~gclk;

  burst_sequencer #(
    .CNT_W        (8),
    .BLANK_CYC    (10),
    .TIMEOUT_CYC  (100),
    .HOLDOFF_CYC  (20),
    .FIRE_MAX_CYC (50)
  ) dut (
    .gclk         (gclk),
    .rstn         (rstn),
    .start        (start),
    .auto_en      (auto_en),
    .abort        (abort),
    .burst_finish (burst_finish),
    .echo_det     (echo_det),
    .burst_en     (burst_en),
    .burst_rstn   (burst_rstn),
    .busy         (busy),
    .tof_valid    (tof_valid),
    .tof_cycles   (tof_cycles),
    .timeout      (timeout),
    .fire_err     (fire_err)
  );

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = i[0]; auto_en = ~i[0]; abort = i[1];
      burst_finish = i[0]; echo_det = ~i[1];
      tick;
    end
    n_checks++;
    if ({burst_en, burst_rstn, busy, tof_valid, timeout, fire_err}
        !== 6'b0 || tof_cycles !== 8'h00) begin
      $display("FAIL reset_outputs got en=%b rn=%b busy=%b v=%b tmo=%b fe=%b tof=%0d want all 0",
               burst_en, burst_rstn, busy, tof_valid, timeout,
               fire_err, tof_cycles);
      n_fail++;
    end
    start = 0; auto_en = 0; abort = 0;
    burst_finish = 0; echo_det = 0;
    rstn = 1'b1;
    tick; tick; tick; tick;
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_release_idle got busy=%b want 0", busy);
      n_fail++;
    end
  endtask

  task automatic test_single_shot;
    int pulses = 0;
    logic exp_en;
    start = 1; tick; start = 0;
    for (int c = 0; c <= 70; c++) begin
      exp_en = (c <= 30);
      n_checks++;
      if (burst_en !== exp_en || burst_rstn !== exp_en) begin
        $display("FAIL single_burst_en c=%0d got en=%b rn=%b want %b",
                 c, burst_en, burst_rstn, exp_en);
        n_fail++;
      end
      if (tof_valid === 1'b1) pulses++;
      if (c == 63) begin
        n_checks++;
        if (tof_valid !== 1'b1 || tof_cycles !== 8'd62 ||
            timeout !== 1'b0) begin
          $display("FAIL single_tof got v=%b tof=%0d tmo=%b want 1 62 0",
                   tof_valid, tof_cycles, timeout);
          n_fail++;
        end
      end
      if (c == 64 || c == 70) begin
        n_checks++;
        if (busy !== 1'b0) begin
          $display("FAIL single_idle c=%0d got busy=%b want 0",
                   c, busy);
          n_fail++;
        end
      end
      burst_finish = (c == 30);
      echo_det = (c >= 60 && c < 66);
      start = (c == 40);
      tick;
    end
    start = 0; burst_finish = 0; echo_det = 0;
    n_checks++;
    if (pulses != 1) begin
      $display("FAIL single_pulses got %0d want 1", pulses);
      n_fail++;
    end
  endtask

  task automatic test_timeout;
    int pulses = 0;
    start = 1; tick; start = 0;
    for (int c = 0; c <= 105; c++) begin
      if (tof_valid === 1'b1) pulses++;
      if (c == 100) begin
        n_checks++;
        if (tof_valid !== 1'b1 || tof_cycles !== 8'hFF ||
            timeout !== 1'b1) begin
          $display("FAIL timeout_result got v=%b tof=%h tmo=%b want 1 ff 1",
                   tof_valid, tof_cycles, timeout);
          n_fail++;
        end
      end
      burst_finish = (c == 2);
      echo_det = (c >= 5 && c < 104);
      tick;
    end
    burst_finish = 0; echo_det = 0;
    n_checks++;
    if (pulses != 1) begin
      $display("FAIL timeout_pulses got %0d want 1", pulses);
      n_fail++;
    end
  endtask

  task automatic test_fire_watchdog;
    int fe = 0;
    int tv = 0;
    start = 1; tick; start = 0;
    for (int c = 0; c <= 55; c++) begin
      if (fire_err === 1'b1) fe++;
      if (tof_valid === 1'b1) tv++;
      if (c == 49) begin
        n_checks++;
        if (burst_en !== 1'b1) begin
          $display("FAIL wdog_fire_c49 got en=%b want 1", burst_en);
          n_fail++;
        end
      end
      if (c == 50) begin
        n_checks++;
        if (fire_err !== 1'b1 || busy !== 1'b0 ||
            burst_rstn !== 1'b0 || burst_en !== 1'b0) begin
          $display("FAIL wdog_expire got fe=%b busy=%b rn=%b en=%b want 1 0 0 0",
                   fire_err, busy, burst_rstn, burst_en);
          n_fail++;
        end
      end
      tick;
    end
    n_checks++;
    if (fe != 1 || tv != 0) begin
      $display("FAIL wdog_pulses got fe=%0d tv=%0d want 1 0", fe, tv);
      n_fail++;
    end
    n_checks++;
    if (tof_cycles !== 8'hFF || timeout !== 1'b1) begin
      $display("FAIL wdog_hold got tof=%h tmo=%b want ff 1",
               tof_cycles, timeout);
      n_fail++;
    end
  endtask

  task automatic test_abort;
    int tv = 0;
    start = 1; tick; start = 0;
    for (int c = 0; c <= 75; c++) begin
      if (tof_valid === 1'b1) tv++;
      if (c == 70) begin
        n_checks++;
        if (busy !== 1'b1) begin
          $display("FAIL abort_pre got busy=%b want 1", busy);
          n_fail++;
        end
      end
      if (c == 71) begin
        n_checks++;
        if (busy !== 1'b0 || burst_en !== 1'b0 ||
            burst_rstn !== 1'b0) begin
          $display("FAIL abort_idle got busy=%b en=%b rn=%b want 0 0 0",
                   busy, burst_en, burst_rstn);
          n_fail++;
        end
      end
      burst_finish = (c == 5);
      abort = (c == 70);
      tick;
    end
    burst_finish = 0; abort = 0;
    n_checks++;
    if (tv != 0 || tof_cycles !== 8'hFF || timeout !== 1'b1) begin
      $display("FAIL abort_hold got tv=%0d tof=%h tmo=%b want 0 ff 1",
               tv, tof_cycles, timeout);
      n_fail++;
    end
    tv = 0;
    start = 1; tick; start = 0;
    for (int c = 0; c <= 105; c++) begin
      if (tof_valid === 1'b1) tv++;
      if (c == 100) begin
        n_checks++;
        if (tof_valid !== 1'b1 || tof_cycles !== 8'd99 ||
            timeout !== 1'b0) begin
          $display("FAIL echo_vs_tmo got v=%b tof=%0d tmo=%b want 1 99 0",
                   tof_valid, tof_cycles, timeout);
          n_fail++;
        end
      end
      burst_finish = (c == 5);
      echo_det = (c >= 97 && c < 103);
      tick;
    end
    burst_finish = 0; echo_det = 0;
    n_checks++;
    if (tv != 1) begin
      $display("FAIL echo_vs_tmo_pulses got %0d want 1", tv);
      n_fail++;
    end
  endtask

  task automatic test_auto_repeat;
    int tv = 0;
    auto_en = 1; tick;
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (burst_en !== 1'b1 || busy !== 1'b1) begin
        $display("FAIL auto_fire_entry m=%0d got en=%b busy=%b want 1 1",
                 m, burst_en, busy);
        n_fail++;
      end
      for (int c = 0; c < 62; c++) begin
        if (tof_valid === 1'b1) tv++;
        if (c == 41) begin
          n_checks++;
          if (tof_valid !== 1'b1 || tof_cycles !== 8'd40 ||
              timeout !== 1'b0) begin
            $display("FAIL auto_tof m=%0d got v=%b tof=%0d tmo=%b want 1 40 0",
                     m, tof_valid, tof_cycles, timeout);
            n_fail++;
          end
        end
        if (m < 2 && c == 61) begin
          n_checks++;
          if (burst_en !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL auto_holdoff m=%0d got en=%b busy=%b want 0 1",
                     m, burst_en, busy);
            n_fail++;
          end
        end
        if (m == 2 && c == 42) begin
          n_checks++;
          if (busy !== 1'b0) begin
            $display("FAIL auto_stop got busy=%b want 0", busy);
            n_fail++;
          end
          break;
        end
        burst_finish = (c == 5);
        echo_det = (c >= 38 && c < 41);
        if (m == 2 && c == 20) auto_en = 0;
        tick;
      end
    end
    burst_finish = 0; echo_det = 0;
    for (int i = 0; i < 5; i++) begin
      if (tof_valid === 1'b1) tv++;
      tick;
    end
    n_checks++;
    if (busy !== 1'b0 || tv != 3) begin
      $display("FAIL auto_end got busy=%b tv=%0d want 0 3", busy, tv);
      n_fail++;
    end
  endtask

  task automatic test_async_reset;
    start = 1; tick; start = 0;
    for (int c = 0; c < 20; c++) tick;
    n_checks++;
    if (burst_en !== 1'b1) begin
      $display("FAIL areset_pre got en=%b want 1", burst_en);
      n_fail++;
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (burst_en !== 1'b0 || burst_rstn !== 1'b0 ||
        busy !== 1'b0 || tof_cycles !== 8'h00 ||
        timeout !== 1'b0) begin
      $display("FAIL areset_mid got en=%b rn=%b busy=%b tof=%0d tmo=%b want 0 0 0 0 0",
               burst_en, burst_rstn, busy, tof_cycles, timeout);
      n_fail++;
    end
    rstn = 1'b1;
    tick; tick;
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL areset_after got busy=%b want 0", busy);
      n_fail++;
    end
  endtask

  initial begin
    rstn = 0; start = 0; auto_en = 0; abort = 0;
    burst_finish = 0; echo_det = 0;
    test_reset;
    test_single_shot;
    test_timeout;
    test_fire_watchdog;
    test_abort;
    test_auto_repeat;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
